// File: rtl/a2c_transmitter.sv
// A2C link transmitter: buffers WORD_W-bit words and shifts them LSB first onto A2C_DT/A2C_CK.
// Define A2C_TX_FIFO_EN for a FIFO_DEPTH-entry word FIFO; otherwise a single holding register.
module a2c_transmitter #(
  parameter int unsigned WORD_W     = 40,
  parameter int unsigned CLK_HALF   = 16,
  parameter int unsigned GAP_CYCLES = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic [WORD_W-1:0] dataIn,
  input  logic              dataValid,
  output logic              dataReady,
  output logic              A2C_DT,
  output logic              A2C_CK,
  output logic              busy,
  output logic              frameDone
);

`ifdef A2C_TX_FIFO_EN
  localparam int unsigned DEPTH = FIFO_DEPTH;
`else
  // Single holding register; FIFO_DEPTH has no effect in this build.
  localparam int unsigned DEPTH = 1 + 0 * FIFO_DEPTH;
`endif
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned HALF_W = $clog2(CLK_HALF) + 1;
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES) + 1;
  localparam int unsigned BIT_W  = 6;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} state_t;

  state_t            r_state, w_state_next;
  logic [HALF_W-1:0] r_half, w_half_next;
  logic [GAP_W-1:0]  r_gap, w_gap_next;
  logic [BIT_W-1:0]  r_bit, w_bit_next;
  logic [WORD_W-1:0] r_shift, w_shift_next;

  logic [CNT_W-1:0]  r_count, w_count_next;
  logic [WORD_W-1:0] w_head;
  logic              w_push, w_pop;
  logic              r_ready, r_busy, r_ck, r_dt, r_done;

  assign w_push       = dataValid & r_ready;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

`ifdef A2C_TX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;

  // Pointers wrap on their own since DEPTH is a power of two.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk50) begin
    if (w_push) r_mem[r_wr_ptr] <= dataIn;
  end

  assign w_head = r_mem[r_rd_ptr];
`else
  logic [WORD_W-1:0] r_hold;

  always_ff @(posedge clk50) begin
    if (w_push) r_hold <= dataIn;
  end

  assign w_head = r_hold;
`endif

  // Occupancy and the registered handshake/status flags derived from next occupancy.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_ready <= (w_count_next != CNT_W'(DEPTH));
      r_busy  <= (w_state_next != S_IDLE) || (w_count_next != '0);
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_half  <= '0;
      r_gap   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_half  <= w_half_next;
      r_gap   <= w_gap_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_half_next  = r_half;
    w_gap_next   = r_gap;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_bit_next   = '0;
          w_half_next  = '0;
          w_state_next = S_LOW;
        end
      end
      S_LOW: begin
        if (r_half == HALF_W'(CLK_HALF - 1)) begin
          w_half_next  = '0;
          w_state_next = S_HIGH;
        end else begin
          w_half_next = r_half + HALF_W'(1);
        end
      end
      S_HIGH: begin
        if (r_half == HALF_W'(CLK_HALF - 1)) begin
          w_half_next = '0;
          if (r_bit == BIT_W'(WORD_W - 1)) begin
            w_gap_next   = '0;
            w_state_next = S_GAP;
          end else begin
            w_shift_next = r_shift >> 1;
            w_bit_next   = r_bit + BIT_W'(1);
            w_state_next = S_LOW;
          end
        end else begin
          w_half_next = r_half + HALF_W'(1);
        end
      end
      S_GAP: begin
        if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
          w_state_next = S_IDLE;
        end else begin
          w_gap_next = r_gap + GAP_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pins lag the state by one cycle; DT only moves once CK has already settled low.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_ck   <= 1'b0;
      r_dt   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_ck   <= (r_state == S_HIGH);
      r_done <= (r_state == S_GAP) && (r_gap == '0);
      if (!r_ck && (r_state != S_HIGH)) begin
        r_dt <= (r_state == S_LOW) ? r_shift[0] : 1'b0;
      end
    end
  end

  assign dataReady = r_ready;
  assign busy      = r_busy;
  assign A2C_CK    = r_ck;
  assign A2C_DT    = r_dt;
  assign frameDone = r_done;

endmodule

// File: tb/tb_a2c_transmitter.sv
// Directed bench for a2c_transmitter with a behavioural rising-edge receiver and pin-stability monitor.
module tb_a2c_transmitter;
  localparam int WORD_W     = 40;
  localparam int CLK_HALF   = 8;
  localparam int GAP_CYCLES = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = WORD_W * 2 * CLK_HALF + GAP_CYCLES + 1;
`ifdef A2C_TX_FIFO_EN
  localparam int NBURST = 6;
`else
  localparam int NBURST = 3;
`endif

  logic              clk50 = 1'b0;
  logic              rst = 1'b1;
  logic [WORD_W-1:0] dataIn = '0;
  logic              dataValid = 1'b0;
  logic              dataReady, A2C_DT, A2C_CK, busy, frameDone;

  a2c_transmitter #(
    .WORD_W(WORD_W), .CLK_HALF(CLK_HALF), .GAP_CYCLES(GAP_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk50(clk50), .rst(rst), .dataIn(dataIn), .dataValid(dataValid), .dataReady(dataReady),
    .A2C_DT(A2C_DT), .A2C_CK(A2C_CK), .busy(busy), .frameDone(frameDone)
  );

  always #10 clk50 = ~clk50;

  int cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver model and monitors, evaluated on the falling clk50 edge.
  logic              prev_ck = 1'b0, prev_dt = 1'b0, prev_done = 1'b0;
  logic              mon_en = 1'b0;
  logic [WORD_W-1:0] rx_word = '0;
  int                rx_bits = 0, rx_rises = 0;
  logic [WORD_W-1:0] rx_q[$];
  int                done_q[$], rise1_q[$], rise_q[$];

  always begin
    @(negedge clk50);
    if (rst) begin
      rx_bits  = 0;
      rx_rises = 0;
    end else begin
      if (mon_en && (A2C_DT !== prev_dt))
        check("dt_stable", 64'({prev_ck, A2C_CK}), 64'd0);
      if (A2C_CK && !prev_ck) begin
        if (rx_bits == 0) rise1_q.push_back(cyc);
        rx_word = {A2C_DT, rx_word[WORD_W-1:1]};
        rx_bits++;
        rx_rises++;
        if (rx_bits == WORD_W) begin
          rx_q.push_back(rx_word);
          rx_bits = 0;
        end
      end
      if (frameDone) begin
        check("done_one_cycle", 64'(prev_done), 64'd0);
        done_q.push_back(cyc);
        rise_q.push_back(rx_rises);
        rx_rises = 0;
      end
    end
    prev_ck   = A2C_CK;
    prev_dt   = A2C_DT;
    prev_done = frameDone;
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [WORD_W-1:0] wget(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 'x;
  endfunction

  task automatic clear_q();
    rx_q.delete();
    done_q.delete();
    rise1_q.delete();
    rise_q.delete();
  endtask

  // Called at a falling edge; returns the clk50 edge index of acceptance.
  task automatic push(input logic [WORD_W-1:0] w, output int acc);
    int n = 0;
    dataIn    = w;
    dataValid = 1'b1;
    while (dataReady !== 1'b1 && n < 2000) begin
      @(negedge clk50);
      n++;
    end
    check("push_timeout", 64'(dataReady), 64'd1);
    acc = cyc + 1;
    @(negedge clk50);
    dataValid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk50);
      k++;
    end
    check("rx_timeout", 64'(rx_q.size() >= n), 64'd1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk50);
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int                acc;
    int                acc_b[6];
    logic              rdy_after[6];
    logic [WORD_W-1:0] burst_w[6];
    logic [WORD_W-1:0] rnd_w[2];
    int                k;

    // Reset and idle after release
    repeat (3) @(negedge clk50);
    check("reset_outputs", 64'({A2C_CK, A2C_DT, busy, frameDone, dataReady}), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk50);
      check("idle_after_reset", 64'({A2C_CK, A2C_DT, busy, frameDone, dataReady}), 64'b00001);
    end

    // Single word: content, edge count and frame timing
    clear_q();
    push(40'hA5_0F0F_1234, acc);
    wait_rx(1, FRAME + 100);
    wait_cyc(acc + FRAME - 1);
    check("busy_in_gap", 64'(busy), 64'd1);
    wait_cyc(acc + FRAME);
    check("busy_fall", 64'(busy), 64'd0);
    check("single_word", 64'(wget(0)), 64'h00A5_0F0F_1234);
    check("single_rises", 64'(qget(rise_q, 0)), 64'(WORD_W));
    check("first_rise", 64'(qget(rise1_q, 0)), 64'(acc + 2 + CLK_HALF));
    check("frame_done", 64'(qget(done_q, 0)), 64'(acc + 2 + WORD_W * 2 * CLK_HALF));
    check("single_frames", 64'(done_q.size()), 64'd1);

    // Burst with dataValid held: stall behaviour, order and back-to-back spacing
    clear_q();
    burst_w[0] = 40'h01_2345_6789;
    burst_w[1] = 40'hFE_DCBA_9876;
    burst_w[2] = 40'h80_0000_0001;
    burst_w[3] = 40'h7F_FFFF_FFFE;
    burst_w[4] = 40'h3C_A55A_C33C;
    burst_w[5] = 40'hC0_FFEE_0042;
    for (int i = 0; i < NBURST; i++) begin
      push(burst_w[i], acc_b[i]);
      rdy_after[i] = dataReady;
    end
    for (int i = 1; i < NBURST; i++) begin
      int   exp_acc;
      logic exp_rdy;
`ifdef A2C_TX_FIFO_EN
      exp_acc = (i <= FIFO_DEPTH) ? acc_b[0] + i : acc_b[0] + 2 + (i - FIFO_DEPTH) * FRAME;
      exp_rdy = 1'(i < FIFO_DEPTH);
`else
      exp_acc = acc_b[0] + 2 + (i - 1) * FRAME;
      exp_rdy = 1'b0;
`endif
      check("burst_accept_cycle", 64'(acc_b[i]), 64'(exp_acc));
      check("burst_ready_after", 64'(rdy_after[i]), 64'(exp_rdy));
    end
`ifdef A2C_TX_FIFO_EN
    check("burst_ready_first", 64'(rdy_after[0]), 64'd1);
`else
    check("burst_ready_first", 64'(rdy_after[0]), 64'd0);
`endif
    wait_rx(NBURST, NBURST * FRAME + 200);
    repeat (20) @(negedge clk50);
    for (int i = 0; i < NBURST; i++) begin
      check("burst_word", 64'(wget(i)), 64'(burst_w[i]));
      check("burst_rises", 64'(qget(rise_q, i)), 64'(WORD_W));
      if (i > 0)
        check("burst_spacing", 64'(qget(done_q, i) - qget(done_q, i - 1)), 64'(FRAME));
    end
    check("gap_to_next_rise", 64'(qget(rise1_q, 1) - qget(done_q, 0)), 64'(GAP_CYCLES + 1 + CLK_HALF));
    check("burst_ready_end", 64'(dataReady), 64'd1);

    // Random words; the monitor checks DT never moves with CK high or changing
    clear_q();
    for (int i = 0; i < 2; i++) begin
      rnd_w[i] = {8'($urandom), 32'($urandom)};
      push(rnd_w[i], acc);
    end
    wait_rx(2, 2 * FRAME + 200);
    for (int i = 0; i < 2; i++)
      check("random_word", 64'(wget(i)), 64'(rnd_w[i]));

    // Reset mid-frame after bit 17, with a second word waiting in the buffer
    repeat (20) @(negedge clk50);
    clear_q();
    push(40'h96_3C0E_7E81, acc);
    push(40'h11_2233_4455, acc);
    k = 0;
    while (rx_bits < 18 && k < 1000) begin
      @(posedge clk50);
      #5;
      k++;
    end
    check("bit17_reached", 64'(rx_bits >= 18), 64'd1);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("rst_async_pins", 64'({A2C_CK, A2C_DT}), 64'd0);
    check("rst_flags", 64'({busy, frameDone, dataReady}), 64'd0);
    repeat (2) @(negedge clk50);
    rst = 1'b0;
    clear_q();
    @(negedge clk50);
    mon_en = 1'b1;
    repeat (20) @(negedge clk50);
    check("buffer_discarded", 64'({busy, A2C_CK}), 64'd0);
    check("no_frame_after_rst", 64'(rise1_q.size()), 64'd0);
    push(40'h5A_C3E1_0F96, acc);
    wait_rx(1, FRAME + 100);
    repeat (30) @(negedge clk50);
    check("post_rst_word", 64'(wget(0)), 64'h005A_C3E1_0F96);
    check("post_rst_rises", 64'(qget(rise_q, 0)), 64'(WORD_W));
    repeat (FRAME) @(negedge clk50);
    check("post_rst_single", 64'(rx_q.size()), 64'd1);
    check("post_rst_idle", 64'({busy, dataReady}), 64'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
